register: RTL and testbench

Parameterised edge-triggered data register with load enable, default 16 bits wide. It is the basic storage element of the CPU datapath and is instantiated for A/D registers and the program-counter backing store. It holds its value indefinitely and captures `in` on a rising clock edge only when `load` is high.

---
 rtl/hw_pkg.sv | 16 +
 rtl/register_bit.sv | 37 +++
 rtl/register.sv | 48 ++++
 tb/tb_register.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/hw_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hw_pkg
// Brief    : Shared datapath word width, word type and reset constant.
// Revision : 1.0
// ============================================================================
package hw_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t WORD_RST = '0;

endpackage : hw_pkg
`default_nettype wire

// File: rtl/register_bit.sv
`default_nettype none
// ============================================================================
// Module   : register_bit
// Brief    : One stored bit: load mux in front of a synchronous-reset D flop.
// Revision : 1.0
// ============================================================================
module register_bit (
    input  logic clk,
    input  logic reset,
    input  logic in,
    input  logic load,
    output logic out
);

    logic bit_d;
    // Power-up value matches the reset value where the flow honours it.
    logic bit_q = 1'b0;

    always_comb begin
        bit_d = bit_q;
        if (load) begin
            bit_d = in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_q <= 1'b0;
        end else begin
            bit_q <= bit_d;
        end
    end

    assign out = bit_q;

endmodule : register_bit
`default_nettype wire

// File: rtl/register.sv
`default_nettype none
// ============================================================================
// Module   : register
// Brief    : WIDTH-bit load-enabled data register (A/D, PC backing store).
//            Define REGISTER_ASSERT_EN to compile in simulation assertions.
// Revision : 1.0
// ============================================================================
module register
    import hw_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    output logic [WIDTH-1:0] out
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bits
            register_bit u_bit (
                .clk   (clk),
                .reset (reset),
                .in    (in[gi]),
                .load  (load),
                .out   (out[gi])
            );
        end
    endgenerate

`ifdef REGISTER_ASSERT_EN
    a_reset_zero : assert property (@(posedge clk) reset |=> (out == '0))
        else $error("register: out not zero after reset at %0t", $time);

    a_load_capture : assert property (@(posedge clk) (!reset && load) |=> (out == $past(in)))
        else $error("register: load did not capture in at %0t", $time);

    a_hold_stable : assert property (@(posedge clk) (!reset && !load) |=> $stable(out))
        else $error("register: out changed while load low at %0t", $time);

    a_ctrl_known : assert property (@(posedge clk) !reset |-> !$isunknown({load, reset}))
        else $error("register: X/Z on load or reset at %0t", $time);
`endif

endmodule : register
`default_nettype wire

// File: tb/tb_register.sv
`default_nettype none
// ============================================================================
// Module   : tb_register
// Brief    : Scoreboard bench for register (directed vectors, WIDTH=16).
// Revision : 1.0
// ============================================================================
module tb_register;
    import hw_pkg::*;

    logic  clk;
    logic  reset;
    logic  load;
    word_t din;
    word_t dout;

    int n_cmp = 0;
    int n_err = 0;
    bit stim_done = 1'b0;

    typedef struct {
        word_t exp;
        string name;
    } exp_t;

    exp_t sb_q[$];

    register #(.WIDTH(WORD_W)) dut (
        .clk   (clk),
        .reset (reset),
        .in    (din),
        .load  (load),
        .out   (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's inputs away from the edge and queue the value out
    // must show after the coming rising edge.
    task automatic step(input logic r, input logic l, input word_t d,
                        input word_t exp, input string name);
        exp_t e;
        @(negedge clk);
        reset = r;
        load  = l;
        din   = d;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_cmp++;
                if (dout !== e.exp) begin
                    n_err++;
                    $display("FAIL %s: out=%h required=%h at %0t", e.name, dout, e.exp, $time);
                end
            end
        end
    end

    initial begin : stimulus
        word_t walk_one;
        word_t prev;
        word_t neg_exp [16] = '{16'hFFFE, 16'hFFFD, 16'hFFFB, 16'hFFF7,
                                16'hFFEF, 16'hFFDF, 16'hFFBF, 16'hFF7F,
                                16'hFEFF, 16'hFDFF, 16'hFBFF, 16'hF7FF,
                                16'hEFFF, 16'hDFFF, 16'hBFFF, 16'h7FFF};
        word_t sus_in  [10] = '{16'h0001, 16'hA5A5, 16'h5A5A, 16'hFFFF, 16'h0000,
                                16'h8000, 16'h7FFF, 16'h1234, 16'hCAFE, 16'h0F0F};
        reset = 1'b1;
        load  = 1'b0;
        din   = '0;

        // Reset held with load high and data present
        step(1'b1, 1'b1, 16'h1234, WORD_RST, "reset_c1");
        step(1'b1, 1'b1, 16'h1234, WORD_RST, "reset_c2");
        step(1'b0, 1'b0, 16'h1234, WORD_RST, "reset_release");

        // Load / hold with -32123
        step(1'b0, 1'b0, 16'h8285, 16'h0000, "hold_before_load");
        step(1'b0, 1'b1, 16'h8285, 16'h8285, "load_neg32123");
        step(1'b0, 1'b0, 16'd11111, 16'h8285, "hold_new_in");
        step(1'b0, 1'b0, 16'd11111, 16'h8285, "hold_new_in_2");

        // Walking one
        prev = 16'h8285;
        for (int k = 0; k < 16; k++) begin
            walk_one = word_t'(1) << k;
            step(1'b0, 1'b0, walk_one, prev, $sformatf("walk1_hold_%0d", k));
            step(1'b0, 1'b1, walk_one, walk_one, $sformatf("walk1_load_%0d", k));
            prev = walk_one;
        end

        // Walking zero: -(2^k)-1 for k=0..14, then 32767
        for (int k = 0; k < 15; k++) begin
            step(1'b0, 1'b1, word_t'(-(32'sd1 <<< k) - 32'sd1), neg_exp[k],
                 $sformatf("walk0_load_%0d", k));
        end
        step(1'b0, 1'b1, word_t'(32767), neg_exp[15], "load_32767");

        // Simultaneous reset and load: reset wins
        step(1'b0, 1'b1, word_t'(12345), 16'h3039, "load_12345");
        step(1'b1, 1'b1, 16'hFFFF, 16'h0000, "reset_beats_load");
        step(1'b0, 1'b1, 16'h0000, 16'h0000, "load_zero");

        // Sustained load with data changing every cycle
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, sus_in[i], sus_in[i], $sformatf("sustain_%0d", i));
        end
        step(1'b0, 1'b0, 16'h4321, 16'h0F0F, "sustain_then_hold");

        stim_done = 1'b1;
    end

    initial begin : finisher
        int budget;
        wait (stim_done);
        budget = 0;
        while (sb_q.size() > 0 && budget < 10) begin
            @(posedge clk);
            #2;
            budget++;
        end
        if (sb_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: pending=%0d required=0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: time=%0t required=stimulus complete", $time);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_register
`default_nettype wire
